board_pop_count_seq: RTL and testbench

//  Sequential, parametrised population counter for board bitmaps (mines, flags, revealed cells).

---
 rtl/board_pop_count_seq.sv | 147 ++++++++++++++
 tb/tb_board_pop_count_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/board_pop_count_seq.sv
// Sequential population counter: counts set bits of (data_in & mask_in), CHUNK bits per clock.
// Optional target compare output is enabled by defining BOARD_POP_COUNT_MATCH_EN.
module board_pop_count_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8,
  localparam int CNT_W = $clog2(WIDTH + 1),
  localparam int NCHK  = (WIDTH + CHUNK - 1) / CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] mask_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
`ifdef BOARD_POP_COUNT_MATCH_EN
  ,
  input  logic [CNT_W-1:0] target_in,
  output logic             match
`endif
);

  localparam int PAD_W = NCHK * CHUNK;
  localparam int PC_W  = $clog2(CHUNK + 1);
  localparam int IDX_W = (NCHK > 1) ? $clog2(NCHK) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [PAD_W-1:0]   vec_r, vec_s;
  logic [CNT_W-1:0]   acc_r, acc_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [PC_W-1:0]    partial_s;
  logic [CNT_W-1:0]   sum_s;
`ifdef BOARD_POP_COUNT_MATCH_EN
  logic [CNT_W-1:0]   target_r, target_s;
  logic               match_r, match_s;
`endif

  function automatic logic [PC_W-1:0] pop_chunk(input logic [CHUNK-1:0] bits);
    logic [PC_W-1:0] sum;
    sum = {PC_W{1'b0}};
    for (int i = 0; i < CHUNK; i++) begin
      sum = sum + PC_W'(bits[i]);
    end
    return sum;
  endfunction

  // The vector is shifted down each cycle, so the current chunk always sits in the low bits;
  // padding above WIDTH-1 was zero-filled at capture.
  assign partial_s = pop_chunk(vec_r[CHUNK-1:0]);
  assign sum_s     = acc_r + CNT_W'(partial_s);

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    vec_s   = vec_r;
    acc_s   = acc_r;
    idx_s   = idx_r;
    count_s = count_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
`ifdef BOARD_POP_COUNT_MATCH_EN
    target_s = target_r;
    match_s  = match_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          busy_s  = 1'b1;
          vec_s   = PAD_W'(data_in & mask_in);
          acc_s   = {CNT_W{1'b0}};
          idx_s   = {IDX_W{1'b0}};
`ifdef BOARD_POP_COUNT_MATCH_EN
          target_s = target_in;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == IDX_W'(NCHK - 1)) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          count_s = sum_s;
`ifdef BOARD_POP_COUNT_MATCH_EN
          match_s = (sum_s == target_r);
`endif
        end else begin
          acc_s = sum_s;
          idx_s = idx_r + IDX_W'(1);
          vec_s = vec_r >> CHUNK;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      vec_r   <= {PAD_W{1'b0}};
      acc_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef BOARD_POP_COUNT_MATCH_EN
      target_r <= {CNT_W{1'b0}};
      match_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      vec_r   <= vec_s;
      acc_r   <= acc_s;
      idx_r   <= idx_s;
      count_r <= count_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
`ifdef BOARD_POP_COUNT_MATCH_EN
      target_r <= target_s;
      match_r  <= match_s;
`endif
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign count = count_r;
`ifdef BOARD_POP_COUNT_MATCH_EN
  assign match = match_r;
`endif

endmodule

// File: tb/tb_board_pop_count_seq.sv
// Directed bench for board_pop_count_seq: 64/8 instance plus a 10/4 instance for the ragged final chunk.
module tb_board_pop_count_seq;

  localparam int NCHK_A = 8;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] data = 64'h0;
  logic [63:0] mask = 64'h0;
  logic        busy, done;
  logic [6:0]  count;
  logic [6:0]  target = 7'd0;
  logic        match;

  logic        start2 = 1'b0;
  logic [9:0]  data2 = 10'h0;
  logic [9:0]  mask2 = 10'h3FF;
  logic        busy2, done2;
  logic [3:0]  count2;
  logic [3:0]  target2 = 4'd0;
  logic        match2;

  int checks = 0;
  int errors = 0;
  logic [6:0] prev_count = 7'd0;

  always #5 clk = ~clk;

  board_pop_count_seq #(.WIDTH(64), .CHUNK(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .data_in(data), .mask_in(mask),
    .busy(busy), .done(done), .count(count)
`ifdef BOARD_POP_COUNT_MATCH_EN
    , .target_in(target), .match(match)
`endif
  );

  board_pop_count_seq #(.WIDTH(10), .CHUNK(4)) dut_b (
    .clk(clk), .rst(rst), .start(start2), .data_in(data2), .mask_in(mask2),
    .busy(busy2), .done(done2), .count(count2)
`ifdef BOARD_POP_COUNT_MATCH_EN
    , .target_in(target2), .match(match2)
`endif
  );

`ifndef BOARD_POP_COUNT_MATCH_EN
  assign match  = 1'b0;
  assign match2 = 1'b0;
`endif

  typedef struct {
    logic [63:0] d;
    logic [63:0] m;
    logic [6:0]  exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full operation on dut_a with cycle-exact busy/done/count checks.
  task automatic run_count(input logic [63:0] d, input logic [63:0] m, input logic [6:0] exp);
    @(negedge clk);
    start = 1'b1; data = d; mask = m;
    @(negedge clk);
    start = 1'b0; data = ~d;
    for (int c = 0; c < NCHK_A; c++) begin
      check("busy_during_run", {63'h0, busy}, 64'h1);
      check("no_done_during_run", {63'h0, done}, 64'h0);
      check("count_holds", {57'h0, count}, {57'h0, prev_count});
      @(negedge clk);
    end
    check("done_pulse", {63'h0, done}, 64'h1);
    check("busy_clear", {63'h0, busy}, 64'h0);
    check("count_result", {57'h0, count}, {57'h0, exp});
    prev_count = exp;
    @(negedge clk);
    check("done_one_cycle", {63'h0, done}, 64'h0);
  endtask

  vec_t vecs [8];
  int pulses;
  int done_at;

  initial begin
    vecs[0] = '{ONES, ONES, 7'd64};
    vecs[1] = '{64'h8000_0000_0000_0001, ONES, 7'd2};
    vecs[2] = '{ONES, 64'h0000_00FF_0000_000F, 7'd12};
    vecs[3] = '{64'h0, ONES, 7'd0};
    vecs[4] = '{64'hAAAA_AAAA_AAAA_AAAA, ONES, 7'd32};
    vecs[5] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 7'd0};
    vecs[6] = '{64'h0123_4567_89AB_CDEF, ONES, 7'd32};
    vecs[7] = '{ONES, 64'h8000_0000_0000_0000, 7'd1};

    repeat (3) @(negedge clk);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_count", {57'h0, count}, 64'h0);
    check("reset_match", {63'h0, match}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_count(vecs[i].d, vecs[i].m, vecs[i].exp);
    end

    // Second start at +3 while busy must be ignored.
    run_count(64'h0, ONES, 7'd0);
    @(negedge clk);
    start = 1'b1; data = ONES; mask = ONES;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; done_at = -1;
    for (int c = 1; c <= 20; c++) begin
      start = (c == 3);
      data  = (c == 3) ? 64'h0 : ONES;
      @(negedge clk);
      if (done) begin
        pulses++;
        done_at = c;
      end
      if (c == 9) check("ignored_start_no_rerun", {63'h0, busy}, 64'h0);
    end
    start = 1'b0;
    check("ignored_start_pulses", pulses, 1);
    check("ignored_start_done_at", done_at, 8);
    check("ignored_start_count", {57'h0, count}, 64'd64);

    // Reset in the middle of a run aborts it.
    @(negedge clk);
    start = 1'b1; data = ONES; mask = ONES;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    check("abort_count", {57'h0, count}, 64'h0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    prev_count = 7'd0;
    run_count(64'h1, ONES, 7'd1);

    // WIDTH=10, CHUNK=4: three chunks, last one padded.
    @(negedge clk);
    start2 = 1'b1; data2 = 10'h3FF;
    @(negedge clk);
    start2 = 1'b0;
    check("w10_busy1", {63'h0, busy2}, 64'h1);
    @(negedge clk);
    check("w10_busy2", {63'h0, busy2}, 64'h1);
    @(negedge clk);
    check("w10_busy3", {63'h0, busy2}, 64'h1);
    check("w10_no_early_done", {63'h0, done2}, 64'h0);
    @(negedge clk);
    check("w10_done", {63'h0, done2}, 64'h1);
    check("w10_count", {60'h0, count2}, 64'd10);
    start2 = 1'b1; data2 = 10'h001;
    @(negedge clk);
    start2 = 1'b0; data2 = 10'h3FF;
    check("b2b_busy", {63'h0, busy2}, 64'h1);
    check("b2b_count_kept", {60'h0, count2}, 64'd10);
    check("b2b_no_done", {63'h0, done2}, 64'h0);
    repeat (3) @(negedge clk);
    check("b2b_done", {63'h0, done2}, 64'h1);
    check("b2b_count", {60'h0, count2}, 64'd1);

`ifdef BOARD_POP_COUNT_MATCH_EN
    target = 7'd64;
    run_count(ONES, ONES, 7'd64);
    check("match_hit", {63'h0, match}, 64'h1);
    target = 7'd63;
    run_count(ONES, ONES, 7'd64);
    check("match_miss", {63'h0, match}, 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
